// File: rtl/mux_pkg.sv
// Shared definitions for the lane-select mux/demux family: default sizes,
// the lane-select width helper and the lane index type.
package mux_pkg;

    // Ceiling log2, usable in constant expressions for parameter defaults.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_LANES = 4;
    localparam int DEFAULT_CNT_W = 16;
    localparam int DEFAULT_SEL_W = clog2(DEFAULT_LANES);

    typedef logic [DEFAULT_SEL_W-1:0] sel_t;

endpackage

// File: rtl/onehot_decoder.sv
// Binary lane index to one-hot lane enable vector.
module onehot_decoder
    import mux_pkg::*;
#(
    parameter int LANES = DEFAULT_LANES,
    parameter int SEL_W = clog2(LANES)
) (
    input  logic [SEL_W-1:0] sel,
    output logic [LANES-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/stream_demux.sv
// One valid/ready producer stream distributed over LANES consumer lanes, each
// lane holding one word so a stalled consumer only blocks words aimed at it.
module stream_demux
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int LANES = DEFAULT_LANES,
    parameter int SEL_W = clog2(LANES),
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rr_mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [LANES-1:0]       out_valid,
    input  logic [LANES-1:0]       out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [SEL_W-1:0]       rr_ptr,
    output logic [CNT_W-1:0]       xfer_count
);

    logic [SEL_W-1:0] target;
    logic             accept;
    logic [LANES-1:0] lane_hit;
    logic [LANES-1:0] load;

    // A lane can take a new word when empty or when it drains this same cycle.
    assign target   = rr_mode ? rr_ptr : in_sel;
    assign in_ready = !rst && (!out_valid[target] || out_ready[target]);
    assign accept   = in_valid && in_ready;

    onehot_decoder #(
        .LANES (LANES),
        .SEL_W (SEL_W)
    ) u_decoder (
        .sel    (target),
        .onehot (lane_hit)
    );

    assign load = lane_hit & {LANES{accept}};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        // Load wins over drain, so a drain+load cycle keeps the lane valid.
        always_ff @(posedge clk) begin
            if (rst) begin
                out_valid[i]                <= 1'b0;
                out_data[i*WIDTH +: WIDTH]  <= '0;
            end else if (load[i]) begin
                out_valid[i]                <= 1'b1;
                out_data[i*WIDTH +: WIDTH]  <= in_data;
            end else if (out_ready[i]) begin
                out_valid[i]                <= 1'b0;
            end
        end
    end

    // The pointer only moves on an accepted word, so a full lane is never skipped.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            xfer_count <= '0;
        end else if (accept) begin
            xfer_count <= xfer_count + 1'b1;
            if (rr_mode) begin
                rr_ptr <= rr_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed vector table, hand-written
// stall/reset sequences and randomized traffic against a lane-level model.
module tb_stream_demux;
    import mux_pkg::*;

    localparam int WIDTH = 8;
    localparam int LANES = 4;

    logic             clk;
    logic             rst;
    logic             rr_mode;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    sel_t             in_sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [31:0]      out_data;
    sel_t             rr_ptr;
    logic [15:0]      xfer_count;

    logic             s_in_ready;
    logic [3:0]       s_out_valid;
    logic [31:0]      s_out_data;
    sel_t             s_rr_ptr;
    logic [3:0]       s_xfer_count;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 0;

    stream_demux #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rr_mode    (rr_mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .rr_ptr     (rr_ptr),
        .xfer_count (xfer_count)
    );

    // Narrow-counter copy on the same inputs so counter wrap is exercised often.
    stream_demux #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(4)) dut_small (
        .clk        (clk),
        .rst        (rst),
        .rr_mode    (rr_mode),
        .in_valid   (in_valid),
        .in_ready   (s_in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out_valid  (s_out_valid),
        .out_ready  (out_ready),
        .out_data   (s_out_data),
        .rr_ptr     (s_rr_ptr),
        .xfer_count (s_xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per-lane occupancy and contents, pointer and word count.
    bit          m_valid [LANES];
    logic [7:0]  m_data  [LANES];
    int          m_ptr;
    int unsigned m_count;

    function automatic bit model_ready();
        int tgt;
        tgt = rr_mode ? m_ptr : int'(in_sel);
        return !rst && (!m_valid[tgt] || out_ready[tgt]);
    endfunction

    always @(posedge clk) begin
        int  tgt;
        bit  acc;
        tgt = rr_mode ? m_ptr : int'(in_sel);
        acc = in_valid && model_ready();
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                m_valid[i] = 0;
                m_data[i]  = 8'h00;
            end
            m_ptr   = 0;
            m_count = 0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (acc && i == tgt) begin
                    m_valid[i] = 1;
                    m_data[i]  = in_data;
                end else if (m_valid[i] && out_ready[i]) begin
                    m_valid[i] = 0;
                end
            end
            if (acc) begin
                m_count = m_count + 1;
                if (rr_mode) m_ptr = (m_ptr + 1) % LANES;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0]  exp_v;
        logic [31:0] exp_d;
        if (check_en) begin
            for (int i = 0; i < LANES; i++) begin
                exp_v[i]         = m_valid[i];
                exp_d[i*8 +: 8]  = m_data[i];
            end
            checkOutput("model_in_ready", 64'(in_ready), 64'(model_ready()));
            checkOutput("model_out_valid", 64'(out_valid), 64'(exp_v));
            checkOutput("model_out_data", 64'(out_data), 64'(exp_d));
            checkOutput("model_rr_ptr", 64'(rr_ptr), 64'(m_ptr));
            checkOutput("model_count", 64'(xfer_count), 64'(m_count % 65536));
            checkOutput("model_small_count", 64'(s_xfer_count), 64'(m_count % 16));
        end
    end

    task automatic driveInputs(input logic r, input logic m, input logic v,
                               input logic [7:0] d, input sel_t s, input logic [3:0] rd);
        rst       = r;
        rr_mode   = m;
        in_valid  = v;
        in_data   = d;
        in_sel    = s;
        out_ready = rd;
    endtask

    // Drive one cycle, check the combinational in_ready, return just after the edge.
    task automatic applyStimulus(input string name, input logic r, input logic m,
                                 input logic v, input logic [7:0] d, input sel_t s,
                                 input logic [3:0] rd, input logic exp_rdy);
        driveInputs(r, m, v, d, s, rd);
        @(negedge clk);
        checkOutput(name, 64'(in_ready), 64'(exp_rdy));
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rr_mode;
        logic        valid;
        logic [7:0]  data;
        sel_t        sel;
        logic [3:0]  ready;
        logic        exp_rdy;
        logic [3:0]  exp_valid;
        sel_t        exp_lane;
        logic [7:0]  exp_data;
        sel_t        exp_ptr;
        logic [15:0] exp_count;
    } vec_t;

    function automatic vec_t mk(input logic m, input logic v, input logic [7:0] d,
                                input sel_t s, input logic [3:0] rd, input logic er,
                                input logic [3:0] ev, input sel_t el, input logic [7:0] ed,
                                input sel_t ep, input logic [15:0] ec);
        vec_t t;
        t.rr_mode = m;   t.valid = v;      t.data = d;       t.sel = s;
        t.ready = rd;    t.exp_rdy = er;   t.exp_valid = ev; t.exp_lane = el;
        t.exp_data = ed; t.exp_ptr = ep;   t.exp_count = ec;
        return t;
    endfunction

    vec_t vecs[11];

    initial begin
        // Directed lane selects, then round robin, then an idle drain cycle.
        vecs[0]  = mk(0, 1, 8'hA1, 2'd3, 4'b1111, 1, 4'b1000, 2'd3, 8'hA1, 2'd0, 16'd1);
        vecs[1]  = mk(0, 1, 8'hB2, 2'd0, 4'b1111, 1, 4'b0001, 2'd0, 8'hB2, 2'd0, 16'd2);
        vecs[2]  = mk(0, 1, 8'hC3, 2'd2, 4'b1111, 1, 4'b0100, 2'd2, 8'hC3, 2'd0, 16'd3);
        vecs[3]  = mk(0, 1, 8'hD4, 2'd1, 4'b1111, 1, 4'b0010, 2'd1, 8'hD4, 2'd0, 16'd4);
        vecs[4]  = mk(1, 1, 8'h10, 2'd3, 4'b1111, 1, 4'b0001, 2'd0, 8'h10, 2'd1, 16'd5);
        vecs[5]  = mk(1, 1, 8'h11, 2'd3, 4'b1111, 1, 4'b0010, 2'd1, 8'h11, 2'd2, 16'd6);
        vecs[6]  = mk(1, 1, 8'h12, 2'd0, 4'b1111, 1, 4'b0100, 2'd2, 8'h12, 2'd3, 16'd7);
        vecs[7]  = mk(1, 1, 8'h13, 2'd0, 4'b1111, 1, 4'b1000, 2'd3, 8'h13, 2'd0, 16'd8);
        vecs[8]  = mk(1, 1, 8'h14, 2'd2, 4'b1111, 1, 4'b0001, 2'd0, 8'h14, 2'd1, 16'd9);
        vecs[9]  = mk(1, 1, 8'h15, 2'd1, 4'b1111, 1, 4'b0010, 2'd1, 8'h15, 2'd2, 16'd10);
        vecs[10] = mk(1, 0, 8'hEE, 2'd0, 4'b1111, 1, 4'b0000, 2'd1, 8'h15, 2'd2, 16'd10);

        // Reset held two cycles with a word offered.
        applyStimulus("reset_in_ready_0", 1, 0, 1, 8'h99, 2'd0, 4'b1111, 0);
        applyStimulus("reset_in_ready_1", 1, 0, 1, 8'h99, 2'd0, 4'b1111, 0);
        checkOutput("reset_out_valid", 64'(out_valid), 64'(4'b0000));
        checkOutput("reset_rr_ptr", 64'(rr_ptr), 64'(0));
        checkOutput("reset_count", 64'(xfer_count), 64'(0));
        checkOutput("reset_out_data", 64'(out_data), 64'(0));
        check_en = 1;

        foreach (vecs[k]) begin
            applyStimulus("tbl_in_ready", 0, vecs[k].rr_mode, vecs[k].valid, vecs[k].data,
                          vecs[k].sel, vecs[k].ready, vecs[k].exp_rdy);
            checkOutput("tbl_out_valid", 64'(out_valid), 64'(vecs[k].exp_valid));
            checkOutput("tbl_lane_data", 64'(out_data[int'(vecs[k].exp_lane)*8 +: 8]),
                        64'(vecs[k].exp_data));
            checkOutput("tbl_rr_ptr", 64'(rr_ptr), 64'(vecs[k].exp_ptr));
            checkOutput("tbl_count", 64'(xfer_count), 64'(vecs[k].exp_count));
        end

        // Lane 2 stalls; lane 1 still flows; releasing lane 2 drains and reloads at once.
        applyStimulus("bp_first_accept", 0, 0, 1, 8'h55, 2'd2, 4'b1011, 1);
        applyStimulus("bp_second_blocked", 0, 0, 1, 8'h66, 2'd2, 4'b1011, 0);
        checkOutput("bp_lane2_held", 64'(out_data[23:16]), 64'(8'h55));
        checkOutput("bp_lane2_valid", 64'(out_valid[2]), 64'(1));
        checkOutput("bp_count_held", 64'(xfer_count), 64'(11));
        applyStimulus("bp_other_lane", 0, 0, 1, 8'h77, 2'd1, 4'b1011, 1);
        checkOutput("bp_other_valid", 64'(out_valid), 64'(4'b0110));
        checkOutput("bp_lane2_stable", 64'(out_data[23:16]), 64'(8'h55));
        applyStimulus("bp_release", 0, 0, 1, 8'h66, 2'd2, 4'b1111, 1);
        checkOutput("bp_reload_valid", 64'(out_valid), 64'(4'b0100));
        checkOutput("bp_reload_data", 64'(out_data[23:16]), 64'(8'h66));

        // Pointer wrap from 3 back to 0.
        applyStimulus("wrap_a", 0, 1, 1, 8'h20, 2'd0, 4'b1111, 1);
        checkOutput("wrap_ptr3", 64'(rr_ptr), 64'(3));
        applyStimulus("wrap_b", 0, 1, 1, 8'h21, 2'd0, 4'b1111, 1);
        checkOutput("wrap_ptr0", 64'(rr_ptr), 64'(0));

        // Round robin must wait on a full lane rather than skip it.
        for (int i = 0; i < 4; i++)
            applyStimulus("rr_fill", 0, 1, 1, 8'h30 + 8'(i), 2'd0, 4'b1110, 1);
        applyStimulus("rr_full_blocked", 0, 1, 1, 8'h40, 2'd0, 4'b1110, 0);
        checkOutput("rr_full_ptr", 64'(rr_ptr), 64'(0));
        checkOutput("rr_full_lane0", 64'(out_data[7:0]), 64'(8'h30));
        checkOutput("rr_full_count", 64'(xfer_count), 64'(19));
        checkOutput("small_count_wrapped", 64'(s_xfer_count), 64'(3));
        applyStimulus("rr_drain_load", 0, 1, 1, 8'h41, 2'd0, 4'b1111, 1);
        checkOutput("rr_drain_load_valid", 64'(out_valid), 64'(4'b0001));
        checkOutput("rr_drain_load_data", 64'(out_data[7:0]), 64'(8'h41));
        checkOutput("rr_drain_load_ptr", 64'(rr_ptr), 64'(1));

        // Mid-operation reset with lanes 0 and 1 occupied.
        applyStimulus("mid_fill", 0, 0, 1, 8'h50, 2'd1, 4'b0000, 1);
        checkOutput("mid_pre_valid", 64'(out_valid), 64'(4'b0011));
        applyStimulus("mid_rst_in_ready", 1, 0, 1, 8'h51, 2'd2, 4'b0000, 0);
        checkOutput("mid_rst_valid", 64'(out_valid), 64'(4'b0000));
        checkOutput("mid_rst_ptr", 64'(rr_ptr), 64'(0));
        checkOutput("mid_rst_count", 64'(xfer_count), 64'(0));
        applyStimulus("mid_after", 0, 0, 0, 8'h52, 2'd0, 4'b1111, 1);
        checkOutput("mid_no_stale", 64'(out_valid), 64'(4'b0000));
        checkOutput("mid_data_clear", 64'(out_data), 64'(0));

        // Random traffic with occasional resets and mode changes.
        begin
            logic m;
            m = 0;
            for (int c = 0; c < 3000; c++) begin
                if ($urandom_range(0, 19) == 0) m = ~m;
                driveInputs($urandom_range(0, 99) == 0, m, $urandom_range(0, 3) != 0,
                            8'($urandom), 2'($urandom), 4'($urandom) | 4'($urandom));
                @(posedge clk);
                #1;
            end
        end

        driveInputs(0, 0, 0, 8'h00, 2'd0, 4'b1111);
        @(negedge clk);
        @(posedge clk);
        check_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
